// File: rtl/bip_mux_2x1_if.sv
// Operand/result bundle for the BIP2 two-input word multiplexer.
// The master drives operands and select; the slave (the mux) returns the results.
interface bip_mux_2x1_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_0;
    logic [DATA_WIDTH-1:0] in_1;
    logic                  sel_2x1_in;
    logic [DATA_WIDTH-1:0] mux_2x1_out;
    logic [DATA_WIDTH-1:0] mux_2x1_q_out;
    logic                  sel_q_out;

    modport master (
        output in_0,
        output in_1,
        output sel_2x1_in,
        input  mux_2x1_out,
        input  mux_2x1_q_out,
        input  sel_q_out
    );

    modport slave (
        input  in_0,
        input  in_1,
        input  sel_2x1_in,
        output mux_2x1_out,
        output mux_2x1_q_out,
        output sel_q_out
    );
endinterface

// File: rtl/bip_mux_2x1.sv
// Two-input word multiplexer for the BIP2 datapath with a combinational result
// and a registered copy (plus registered select) for pipelined consumers.
module bip_mux_2x1 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    bip_mux_2x1_if.slave mux_if
);

    logic [DATA_WIDTH-1:0] mux_d;
    logic [DATA_WIDTH-1:0] mux_q;
    logic                  sel_d;
    logic                  sel_q;

    // An unknown select falls to the default arm so in_0 wins instead of
    // holding or merging a stale value.
    always_comb begin
        mux_d = mux_if.in_0;
        case (mux_if.sel_2x1_in)
            1'b1:    mux_d = mux_if.in_1;
            default: mux_d = mux_if.in_0;
        endcase
        sel_d = mux_if.sel_2x1_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mux_q <= '0;
            sel_q <= 1'b0;
        end else begin
            mux_q <= mux_d;
            sel_q <= sel_d;
        end
    end

    assign mux_if.mux_2x1_out   = mux_d;
    assign mux_if.mux_2x1_q_out = mux_q;
    assign mux_if.sel_q_out     = sel_q;

endmodule

// File: tb/tb_bip_mux_2x1.sv
// Randomised and directed check of bip_mux_2x1 at widths 16 and 8 against a
// bench-side selection model.
module tb_bip_mux_2x1;

    logic clk_in = 1'b0;
    logic rst_in;

    always #5 clk_in = ~clk_in;

    bip_mux_2x1_if #(.DATA_WIDTH(16)) m16 ();
    bip_mux_2x1_if #(.DATA_WIDTH(8))  m8 ();

    bip_mux_2x1 #(.DATA_WIDTH(16)) dut16 (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .mux_if (m16.slave)
    );

    bip_mux_2x1 #(.DATA_WIDTH(8)) dut8 (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .mux_if (m8.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // bench-side copies of what was driven, used by the model
    logic [15:0] a16, b16;
    logic        s16;
    logic [7:0]  a8, b8;
    logic        s8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pick16(input logic [15:0] a, input logic [15:0] b, input logic s);
        return (s === 1'b1) ? b : a;
    endfunction

    function automatic logic [7:0] pick8(input logic [7:0] a, input logic [7:0] b, input logic s);
        return (s === 1'b1) ? b : a;
    endfunction

    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic s);
        a16 = a; b16 = b; s16 = s;
        m16.in_0 = a; m16.in_1 = b; m16.sel_2x1_in = s;
        #1;
        chk("comb16", m16.mux_2x1_out, pick16(a, b, s));
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s);
        a8 = a; b8 = b; s8 = s;
        m8.in_0 = a; m8.in_1 = b; m8.sel_2x1_in = s;
        #1;
        chk("comb8", m8.mux_2x1_out, pick8(a, b, s));
    endtask

    // One rising edge; registered outputs must show what was presented at it.
    task automatic tick();
        logic [15:0] eq16;
        logic [7:0]  eq8;
        logic        es16, es8;
        @(posedge clk_in);
        eq16 = rst_in ? 16'h0 : pick16(a16, b16, s16);
        es16 = rst_in ? 1'b0  : s16;
        eq8  = rst_in ? 8'h0  : pick8(a8, b8, s8);
        es8  = rst_in ? 1'b0  : s8;
        #1;
        chk("q16",    m16.mux_2x1_q_out, eq16);
        chk("selq16", m16.sel_q_out,     es16);
        chk("q8",     m8.mux_2x1_q_out,  eq8);
        chk("selq8",  m8.sel_q_out,      es8);
        chk("comb16_after_edge", m16.mux_2x1_out, pick16(a16, b16, s16));
    endtask

    initial begin
        rst_in = 1'b1;
        drive16(16'h0000, 16'h0000, 1'b0);
        drive8(8'h00, 8'h00, 1'b0);
        tick();
        rst_in = 1'b0;

        drive16(16'h0000, 16'h0049, 1'b1);
        drive16(16'h0000, 16'h0749, 1'b1);

        drive16(16'h0000, 16'h0749, 1'b1);
        drive16(16'h0000, 16'h0749, 1'b0);
        drive16(16'h0000, 16'h0749, 1'b1);
        drive16(16'h0000, 16'h0749, 1'b0);

        drive16(16'h0064, 16'h0749, 1'b0);
        drive16(16'h0064, 16'h0749, 1'b1);
        drive16(16'h0000, 16'h0749, 1'b1);
        chk("unselected_ignored", m16.mux_2x1_out, 32'h0749);
        tick();

        // mid-stream reset clears registered outputs but not the combinational path
        rst_in = 1'b1;
        drive16(16'h0000, 16'hFFFF, 1'b1);
        tick();
        chk("rst_q_zero",  m16.mux_2x1_q_out, 32'h0);
        chk("rst_comb",    m16.mux_2x1_out,   32'hFFFF);
        rst_in = 1'b0;

        drive16(16'h1234, 16'hABCD, 1'b0);
        tick();
        chk("edgeN_q",    m16.mux_2x1_q_out, 32'h1234);
        chk("edgeN_sel",  m16.sel_q_out,     32'h0);
        drive16(16'h1234, 16'hABCD, 1'b1);
        tick();
        chk("edgeN1_q",   m16.mux_2x1_q_out, 32'hABCD);
        chk("edgeN1_sel", m16.sel_q_out,     32'h1);

        drive8(8'h00, 8'hFF, 1'b1);
        chk("w8_comb", m8.mux_2x1_out, 32'hFF);
        tick();
        chk("w8_q", m8.mux_2x1_q_out, 32'hFF);

        // unknown select resolves to in_0 on the combinational path
        m16.sel_2x1_in = 1'bx;
        #1;
        chk("selx_in0", m16.mux_2x1_out, {16'h0, a16});
        m16.sel_2x1_in = s16;
        #1;

        for (int i = 0; i < 400; i++) begin
            rst_in = ($urandom_range(0, 15) == 0);
            drive16(16'($urandom), 16'($urandom), 1'($urandom));
            drive8(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                drive16(16'($urandom), b16, s16);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bip_mux_2x1.md
# bip_mux_2x1

Parameterised two-input word multiplexer for the BIP2 datapath. It selects one of two DATA_WIDTH-bit operands with a single select bit, typically choosing between the accumulator source and the immediate/memory operand. The select result is available combinationally on `mux_2x1_out` and as a registered copy on `mux_2x1_q_out` for pipelined consumers. One clock domain; synchronous, active-high reset.

## Interface
- DATA_WIDTH, 16, width of both data inputs and both outputs.

- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- in_0  input  DATA_WIDTH  operand selected when `sel_2x1_in`=0.
- in_1  input  DATA_WIDTH  operand selected when `sel_2x1_in`=1.
- sel_2x1_in  input  1  select.
- mux_2x1_out  output  DATA_WIDTH  combinational select result.
- mux_2x1_q_out  output  DATA_WIDTH  registered select result.
- sel_q_out  output  1  registered copy of `sel_2x1_in`, aligned with `mux_2x1_q_out`.

## Operation
- mux_2x1_out = sel_2x1_in ? in_1 : in_0.
  - Pure combinational logic; no latches.
  - Unaffected by clk_in and rst_in.
- Select is X or Z: mux_2x1_out is in_0 in synthesis.
  - Simulation models must not propagate a stale value.
  - A `default` branch drives in_0.
- Width rules:
  - Inputs and outputs are exactly DATA_WIDTH bits.
  - No sign handling and no extension inside the block.
  - The caller is responsible for sizing narrower operands. Zero-extension by the language is acceptable.
- Registered path, at each rising clk_in edge:
  - rst_in=1: mux_2x1_q_out <= 0 and sel_q_out <= 0.
  - Otherwise: mux_2x1_q_out <= mux_2x1_out and sel_q_out <= sel_2x1_in.
- No enable, no handshake. The register loads every cycle.

## Timing
- mux_2x1_out:
  - Zero-cycle latency.
  - Follows any change of in_0, in_1 or sel_2x1_in within the same delta and time step. Only combinational delay applies.
- mux_2x1_q_out and sel_q_out:
  - One-cycle latency. They show the values sampled at the previous rising edge.
- Reset values: mux_2x1_q_out = 0 and sel_q_out = 0 from the first edge with rst_in=1.
  - Reset does not clear mux_2x1_out.
- Reset asserted mid-stream:
  - The registered outputs clear at that edge.
  - The first valid registered sample appears one edge after rst_in deasserts.
- Simultaneous input and select change: mux_2x1_out reflects the new input on the new select. There is no glitch requirement beyond settling within the time step.

## Test plan
- in_0=0x0000, in_1=0x0049, sel=1 -> mux_2x1_out=0x0049. Then in_1=0x0749 -> mux_2x1_out=0x0749 with zero delay.
- Toggle sel 1->0->1->0 with in_0=0x0000 and in_1=0x0749 -> mux_2x1_out alternates 0x0749, 0x0000, 0x0749, 0x0000. The output follows each toggle immediately.
- sel=0, change in_0 to 0x0064 -> mux_2x1_out=0x0064. Then sel=1 -> 0x0749. Then in_0=0x0000 while sel=1 -> output stays 0x0749 (unselected input ignored).
- rst_in=1 for one edge while in_1=0xFFFF and sel=1 -> after the edge mux_2x1_q_out=0x0000, sel_q_out=0, and mux_2x1_out=0xFFFF.
- rst_in=0, in_0=0x1234, in_1=0xABCD, sel=0 at edge N, then sel=1 at edge N+1 -> mux_2x1_q_out is 0x1234 after N and 0xABCD after N+1. sel_q_out is 0 then 1.
- Drive DATA_WIDTH=8 instance with in_1=0xFF, in_0=0x00, sel=1 -> mux_2x1_out=0xFF. The registered copy is 0xFF one edge later.
